seg_pair_reader: RTL and testbench

- Inverse of the two-digit 7-segment driver chip: watches a time-multiplexed, active-low segment bus plus two digit-select lines and recovers the displayed number.
- Debounces each digit's pattern and decodes it back to BCD.
- Once both digits are captured, emits a binary value 0..99 with a one-cycle valid strobe.
- Used as a readback/self-check chip wired to the segment outputs of the display chip.

---
 rtl/seg_pair_if.sv | 18 +
 rtl/seg_pair_reader.sv | 186 ++++++++++++++++++
 tb/tb_seg_pair_reader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seg_pair_if.sv
// Segment-bus readback interface: display-side inputs and decoded results.
interface seg_pair_if;
  logic [6:0] seg;
  logic       sel_hi;
  logic       sel_lo;
  logic [6:0] value;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       valid;
  logic       err;

  // Bench / display side drives the bus and watches the results
  modport master (output seg, sel_hi, sel_lo,
                  input  value, tens, ones, valid, err);
  // Reader side
  modport slave  (input  seg, sel_hi, sel_lo,
                  output value, tens, ones, valid, err);
endinterface

// File: rtl/seg_pair_reader.sv
// Recovers a two-digit number from a multiplexed, active-low 7-segment bus.
// Each digit is debounced, decoded to BCD, and a full frame emits value/valid.
module seg_pair_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic      clk,
  input  logic      rst,
  seg_pair_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] STB = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HAVE_HI = 2'd1;
  localparam logic [1:0] HAVE_LO = 2'd2;
  localparam logic [1:0] EMIT    = 2'd3;

  // Returns {illegal, digit}; blank is accepted only where blank_ok is set.
  function automatic logic [4:0] dec(input logic [6:0] s, input logic blank_ok);
    case (s)
      7'h01: dec = 5'd0;
      7'h4F: dec = 5'd1;
      7'h12: dec = 5'd2;
      7'h06: dec = 5'd3;
      7'h4C: dec = 5'd4;
      7'h24: dec = 5'd5;
      7'h60: dec = 5'd6;
      7'h0F: dec = 5'd7;
      7'h00: dec = 5'd8;
      7'h0C: dec = 5'd9;
      7'h7F: dec = blank_ok ? 5'd0 : 5'h10;
      default: dec = 5'h10;
    endcase
  endfunction

  logic [6:0]    s_seg_q, s_seg_d, p_seg_q, p_seg_d;
  logic          s_hi_q, s_hi_d, s_lo_q, s_lo_d;
  logic          p_dig_q, p_dig_d, p_act_q, p_act_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    hi_dig_q, hi_dig_d, lo_dig_q, lo_dig_d;
  logic          hi_bad_q, hi_bad_d, lo_bad_q, lo_bad_d;
  logic [3:0]    tens_q, tens_d, ones_q, ones_d;
  logic [6:0]    value_q, value_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic          act, same, cap, cap_hi, cap_lo;
  logic [4:0]    cur;

  // Input sample stage plus a copy of the previous sample for comparison
  always_comb begin
    s_seg_d = bus.seg;
    s_hi_d  = bus.sel_hi;
    s_lo_d  = bus.sel_lo;
    p_seg_d = s_seg_q;
    p_dig_d = s_hi_q;
    p_act_d = s_hi_q ^ s_lo_q;
  end

  // Stability counter: saturates at STB so a steady digit captures only once
  always_comb begin
    act   = s_hi_q ^ s_lo_q;
    same  = p_act_q && (p_dig_q == s_hi_q) && (p_seg_q == s_seg_q);
    cnt_d = '0;
    if (act) begin
      if (same) cnt_d = (cnt_q == STB) ? cnt_q : cnt_q + 1'b1;
      else      cnt_d = CW'(1);
    end
    // With STB=1 the counter may already sit at STB from a different pattern,
    // so a capture is the first cycle of a run at STB, not merely a transition.
    cap    = act && (cnt_d == STB) && !(same && (cnt_q == STB));
    cap_hi = cap && s_hi_q;
    cap_lo = cap && s_lo_q;
    cur    = dec(s_seg_q, s_hi_q);
  end

  // Frame FSM: gather both digits in either order, then emit or flag an error
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    hi_dig_d = hi_dig_q;
    hi_bad_d = hi_bad_q;
    lo_dig_d = lo_dig_q;
    lo_bad_d = lo_bad_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (cap_hi) begin
      hi_dig_d = cur[3:0];
      hi_bad_d = cur[4];
    end
    if (cap_lo) begin
      lo_dig_d = cur[3:0];
      lo_bad_d = cur[4];
    end
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (cap_hi)      state_d = HAVE_HI;
        else if (cap_lo) state_d = HAVE_LO;
      end
      HAVE_HI, HAVE_LO: begin
        if ((state_q == HAVE_HI && cap_lo) || (state_q == HAVE_LO && cap_hi)) begin
          state_d = EMIT;
        end else if (cap) begin
          tmo_d = '0;
        end else if (tmo_q == TMO) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        // EMIT: captures in this cycle are dropped; stored patterns are final
        hi_dig_d = hi_dig_q;
        hi_bad_d = hi_bad_q;
        lo_dig_d = lo_dig_q;
        lo_bad_d = lo_bad_q;
        if (!hi_bad_q && !lo_bad_q) begin
          tens_d  = hi_dig_q;
          ones_d  = lo_dig_q;
          value_d = {hi_dig_q, 3'b000} + {2'b00, hi_dig_q, 1'b0} + {3'b000, lo_dig_q};
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
    endcase
  end

  // All state; reset discards any partial frame immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_seg_q  <= '0;
      s_hi_q   <= 1'b0;
      s_lo_q   <= 1'b0;
      p_seg_q  <= '0;
      p_dig_q  <= 1'b0;
      p_act_q  <= 1'b0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      state_q  <= IDLE;
      hi_dig_q <= '0;
      hi_bad_q <= 1'b0;
      lo_dig_q <= '0;
      lo_bad_q <= 1'b0;
      tens_q   <= '0;
      ones_q   <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s_seg_q  <= s_seg_d;
      s_hi_q   <= s_hi_d;
      s_lo_q   <= s_lo_d;
      p_seg_q  <= p_seg_d;
      p_dig_q  <= p_dig_d;
      p_act_q  <= p_act_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      state_q  <= state_d;
      hi_dig_q <= hi_dig_d;
      hi_bad_q <= hi_bad_d;
      lo_dig_q <= lo_dig_d;
      lo_bad_q <= lo_bad_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign bus.value = value_q;
  assign bus.tens  = tens_q;
  assign bus.ones  = ones_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_seg_pair_reader.sv
// Directed bench for seg_pair_reader: frames, blanks, bouncing, bad patterns,
// timeout, mid-frame reset and the no-active-digit case.
module tb_seg_pair_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   vcnt = 0;
  int   ecnt = 0;
  int   both = 0;
  int   v0, e0;

  seg_pair_if bus ();

  seg_pair_reader #(.STABLE_CYCLES(4), .TIMEOUT(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the rising edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid) vcnt <= vcnt + 1;
      if (bus.err)   ecnt <= ecnt + 1;
      if (bus.valid && bus.err) both <= both + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic hi, input logic lo, input logic [6:0] s, input int n);
    bus.sel_hi = hi;
    bus.sel_lo = lo;
    bus.seg    = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic outs(input string tag, input int v, input int t, input int o);
    chk({tag, "_value"}, int'(bus.value), v);
    chk({tag, "_tens"},  int'(bus.tens),  t);
    chk({tag, "_ones"},  int'(bus.ones),  o);
  endtask

  initial begin
    bus.seg = 7'h7F; bus.sel_hi = 1'b0; bus.sel_lo = 1'b0;
    repeat (3) @(negedge clk);
    outs("reset", 0, 0, 0);
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_err", int'(bus.err), 0);
    rst = 1'b0;
    drive(0, 0, 7'h7F, 2);

    // 1: tens 2, ones 9
    v0 = vcnt; e0 = ecnt;
    drive(1, 0, 7'h12, 4);
    drive(0, 1, 7'h0C, 4);
    drive(0, 0, 7'h7F, 6);
    chk("f29_valid_pulses", vcnt - v0, 1);
    chk("f29_err_pulses", ecnt - e0, 0);
    outs("f29", 29, 2, 9);

    // 2: ones first, blank tens
    v0 = vcnt;
    drive(0, 1, 7'h4F, 4);
    drive(1, 0, 7'h7F, 4);
    drive(0, 0, 7'h7F, 6);
    chk("f01_valid_pulses", vcnt - v0, 1);
    outs("f01", 1, 0, 1);

    // 3: bouncing tens pattern never settles
    v0 = vcnt; e0 = ecnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 7'h06, 2);
      drive(1, 0, 7'h24, 2);
    end
    drive(0, 0, 7'h7F, 6);
    chk("bounce_valid", vcnt - v0, 0);
    chk("bounce_err", ecnt - e0, 0);

    // 4: illegal ones pattern -> err at emit, outputs held
    v0 = vcnt; e0 = ecnt;
    drive(1, 0, 7'h7F, 4);
    drive(0, 1, 7'h55, 4);
    drive(0, 0, 7'h7F, 6);
    chk("badpat_err", ecnt - e0, 1);
    chk("badpat_valid", vcnt - v0, 0);
    outs("badpat", 1, 0, 1);

    // 5: tens captured, ones never arrives -> timeout
    v0 = vcnt; e0 = ecnt;
    drive(1, 0, 7'h60, 4);
    drive(0, 0, 7'h7F, 1000);
    chk("tmo_early_err", ecnt - e0, 0);
    drive(0, 0, 7'h7F, 40);
    chk("tmo_err", ecnt - e0, 1);
    chk("tmo_valid", vcnt - v0, 0);
    outs("tmo_hold", 1, 0, 1);
    drive(1, 0, 7'h0F, 4);
    drive(0, 1, 7'h00, 4);
    drive(0, 0, 7'h7F, 6);
    outs("f78", 78, 7, 8);

    // 6: reset after a tens capture discards it
    drive(1, 0, 7'h4F, 4);
    drive(0, 0, 7'h7F, 2);
    rst = 1'b1;
    drive(0, 0, 7'h7F, 2);
    outs("midrst", 0, 0, 0);
    rst = 1'b0;
    v0 = vcnt;
    drive(0, 1, 7'h06, 4);
    drive(0, 0, 7'h7F, 6);
    chk("midrst_lo_only", vcnt - v0, 0);
    drive(1, 0, 7'h24, 4);
    drive(0, 0, 7'h7F, 6);
    chk("midrst_recap", vcnt - v0, 1);
    outs("f53", 53, 5, 3);

    // 7: both selects high is never an active digit
    v0 = vcnt; e0 = ecnt;
    drive(1, 1, 7'h01, 10);
    drive(0, 0, 7'h7F, 3);
    chk("both_sel_valid", vcnt - v0, 0);
    drive(0, 1, 7'h4F, 4);
    drive(0, 0, 7'h7F, 6);
    chk("both_sel_nocap", vcnt - v0, 0);
    chk("both_sel_err", ecnt - e0, 0);
    outs("both_sel_hold", 53, 5, 3);

    chk("valid_err_overlap", both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
